aes_key_schedule: RTL and testbench

Runtime-configurable AES key schedule engine for 128-, 192- and 256-bit keys.
- On a start pulse it expands the key one 32-bit word per cycle into an internal round-key buffer.
- Once the schedule is complete, any round key can be read by index, so encryption (forward order) and decryption (reverse order) share one schedule.
- Sits between key load and the round datapath; the cipher core reads round keys by index instead of consuming a streaming key.

---
 rtl/aes_ks_pkg.sv | 49 ++++
 rtl/aes_key_schedule_if.sv | 21 ++
 rtl/aes_subword.sv | 11 +
 rtl/ks_word_gen.sv | 14 +
 rtl/aes_key_schedule.sv | 109 ++++++++++
 tb/tb_aes_key_schedule.sv | 262 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_ks_pkg.sv
// aes_ks_pkg: shared types, lookups and GF(2^8) helpers for the AES key schedule (InvMixColumns helper under AES_KS_EQINV_EN)
package aes_ks_pkg;
  typedef enum logic [1:0] {KL128, KL192, KL256, KLRSV} keylen_t;
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;
  localparam logic [7:0] RCON_RST = 8'h01;
  function automatic logic [3:0] nk_of(keylen_t kl);
    return kl == KL256 ? 4'd8 : kl == KL192 ? 4'd6 : 4'd4;
  endfunction
  function automatic logic [3:0] nr_of(keylen_t kl);
    return kl == KL256 ? 4'd14 : kl == KL192 ? 4'd12 : 4'd10;
  endfunction
  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // inverse is x^254 (zero maps to zero), followed by the AES affine map
  function automatic logic [7:0] sbox(logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
`ifdef AES_KS_EQINV_EN
  function automatic logic [31:0] inv_mix_col(logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction
  function automatic logic [127:0] inv_mix_key(logic [127:0] k);
    return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]), inv_mix_col(k[63:32]), inv_mix_col(k[31:0])};
  endfunction
`endif
endpackage

// File: rtl/aes_key_schedule_if.sv
// aes_key_schedule_if: control and read-port bundle of the key schedule (rd_inv present under AES_KS_EQINV_EN)
interface aes_key_schedule_if #(parameter int KMAX = 256);
  logic start;
  logic [1:0] keylen;
  logic [KMAX-1:0] key;
  logic busy;
  logic ready;
  logic [3:0] nr;
  logic rd_en;
  logic [3:0] rd_round;
  logic rd_valid;
  logic [127:0] rd_key;
`ifdef AES_KS_EQINV_EN
  logic rd_inv;
  modport master(output start, keylen, key, rd_en, rd_round, rd_inv, input busy, ready, nr, rd_valid, rd_key);
  modport slave(input start, keylen, key, rd_en, rd_round, rd_inv, output busy, ready, nr, rd_valid, rd_key);
`else
  modport master(output start, keylen, key, rd_en, rd_round, input busy, ready, nr, rd_valid, rd_key);
  modport slave(input start, keylen, key, rd_en, rd_round, output busy, ready, nr, rd_valid, rd_key);
`endif
endinterface

// File: rtl/aes_subword.sv
// aes_subword: S-box substitution of each byte of a 32-bit word
module aes_subword
  import aes_ks_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);
  for (genvar b = 0; b < 4; b++) begin : g_sb
    assign y[8*b +: 8] = sbox(a[8*b +: 8]);
  end
endmodule

// File: rtl/ks_word_gen.sv
// ks_word_gen: combinational next key-schedule word from the newest and oldest window words
module ks_word_gen (
  input  logic [31:0] newest,
  input  logic [31:0] oldest,
  input  logic [7:0]  rcon,
  input  logic        rot,
  input  logic        sub,
  output logic [31:0] w
);
  logic [31:0] sw_in, sw;
  assign sw_in = rot ? {newest[23:0], newest[31:24]} : newest;
  aes_subword u_sub (.a(sw_in), .y(sw));
  assign w = oldest ^ (rot ? sw ^ {rcon, 24'h0} : sub ? sw : newest);
endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: AES-128/192/256 key expansion into an indexed round-key buffer (AES_KS_EQINV_EN adds inverse-cipher read keys)
module aes_key_schedule
  import aes_ks_pkg::*;
#(
  parameter int KMAX   = 256,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic reset,
  aes_key_schedule_if.slave bus
);
  localparam int NKMAX = KMAX / 32;
  localparam int DEPTH = 4 * (NKMAX + 7);
  localparam int WW    = $clog2(NKMAX);
  if (RD_LAT != 1) begin : g_bad_lat
    $error("aes_key_schedule: RD_LAT must be 1");
  end
  state_t state, nxt;
  logic [3:0] nk_q, nr_q, ph_q;
  logic [5:0] i_q, ri;
  logic [7:0] rcon_q;
  logic [31:0] win [NKMAX];
  logic [31:0] kbuf [DEPTH];
  logic [31:0] w_new;
  logic [127:0] raw, sel;
  logic [WW-1:0] oi;
  logic accept, last, rot, sub, rd_ok;
  // next state, status outputs and read-port decode
  always_comb begin
    accept = bus.start && bus.keylen != 2'd3 && (state == IDLE || state == DONE);
    last = i_q == {nr_q + 4'd1, 2'b00} - 6'd1;
    nxt = accept ? LOAD : state == LOAD ? EXPAND : (state == EXPAND && last) ? DONE : state;
    bus.busy = state == LOAD || state == EXPAND;
    bus.ready = state == DONE;
    bus.nr = bus.ready ? nr_q : 4'd0;
    rot = ph_q == 4'd0;
    sub = nk_q == 4'd8 && ph_q == 4'd4;
    oi = WW'(nk_q - 4'd1);
    ri = {bus.rd_round, 2'b00};
    raw = {kbuf[ri], kbuf[ri + 6'd1], kbuf[ri + 6'd2], kbuf[ri + 6'd3]};
    rd_ok = bus.rd_en && bus.ready && bus.rd_round <= nr_q;
`ifdef AES_KS_EQINV_EN
    sel = (bus.rd_inv && bus.rd_round != 4'd0 && bus.rd_round < nr_q) ? inv_mix_key(raw) : raw;
`else
    sel = raw;
`endif
  end
  ks_word_gen u_gen (
    .newest(win[0]),
    .oldest(win[oi]),
    .rcon  (rcon_q),
    .rot   (rot),
    .sub   (sub),
    .w     (w_new)
  );
  // state register
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : nxt;
  end
  // key size latch, word index, phase (i mod Nk) and rcon sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      nk_q <= 4'd0;
      nr_q <= 4'd0;
      i_q <= 6'd0;
      ph_q <= 4'd0;
      rcon_q <= RCON_RST;
    end else begin
      if (accept) begin
        nk_q <= nk_of(keylen_t'(bus.keylen));
        nr_q <= nr_of(keylen_t'(bus.keylen));
      end
      if (state == LOAD) begin
        i_q <= 6'(nk_q);
        ph_q <= 4'd0;
        rcon_q <= RCON_RST;
      end else if (state == EXPAND) begin
        i_q <= i_q + 6'd1;
        ph_q <= ph_q == nk_q - 4'd1 ? 4'd0 : ph_q + 4'd1;
        rcon_q <= rot ? xtime(rcon_q) : rcon_q;
      end
    end
  end
  // round-key buffer and sliding window; window[0] is newest, window[Nk-1] oldest
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      for (int j = 0; j < NKMAX; j++) begin
        if (j < int'(nk_q)) begin
          kbuf[j] <= bus.key[KMAX-1-32*j -: 32];
          win[j] <= bus.key[KMAX+31-32*(int'(nk_q)-j) -: 32];
        end
      end
    end else if (state == EXPAND) begin
      kbuf[i_q] <= w_new;
      win[0] <= w_new;
      for (int j = 1; j < NKMAX; j++) win[j] <= win[j-1];
    end
  end
  // registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rd_valid <= 1'b0;
      bus.rd_key <= '0;
    end else begin
      bus.rd_valid <= rd_ok;
      bus.rd_key <= rd_ok ? sel : '0;
    end
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: self-checking bench for aes_key_schedule against a FIPS-197 style reference model
module tb_aes_key_schedule;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  aes_key_schedule_if #(.KMAX(256)) ks ();
  aes_key_schedule #(.KMAX(256), .RD_LAT(1)) dut (.clk(clk), .reset(reset), .bus(ks));

  typedef struct {
    int kl;
    logic [255:0] key;
    int lat;
    int nr;
    int rnd;
    logic [127:0] exp;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb [256];
  logic [31:0] mw [60];
  int m_nk, m_nr;

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    int p, x;
    p = 0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
    end
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model(input int kl, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0] rc;
    m_nk = 4 + 2 * kl;
    m_nr = m_nk + 6;
    rc = 8'h01;
    for (int i = 0; i < m_nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = m_nk; i < 4 * (m_nr + 1); i++) begin
      t = mw[i-1];
      if (i % m_nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (m_nk == 8 && i % m_nk == 4) t = subw(t);
      mw[i] = mw[i-m_nk] ^ t;
    end
  endtask

  function automatic logic [127:0] rk(int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

`ifdef AES_KS_EQINV_EN
  function automatic logic [127:0] imc(logic [127:0] k);
    logic [7:0] cf [4];
    logic [7:0] a [4];
    logic [7:0] b;
    logic [127:0] r;
    cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = k[127-32*c-8*j -: 8];
      for (int j = 0; j < 4; j++) begin
        b = 8'h00;
        for (int m = 0; m < 4; m++) b = b ^ gm(a[m], cf[(m-j+4)%4]);
        r[127-32*c-8*j -: 8] = b;
      end
    end
    return r;
  endfunction
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic start_run(input int kl, input logic [255:0] key, input int glitch, output int lat);
    ks.keylen = 2'(kl);
    ks.key = key;
    ks.start = 1'b1;
    tick();
    ks.start = 1'b0;
    lat = 0;
    while (!ks.ready && lat < 200) begin
      if (lat == glitch) begin
        ks.start = 1'b1;
        ks.keylen = 2'd0;
        ks.key = ~key;
      end
      tick();
      ks.start = 1'b0;
      ks.keylen = 2'(kl);
      ks.key = key;
      lat++;
    end
  endtask

  task automatic read(input int r, output logic v, output logic [127:0] k);
    ks.rd_en = 1'b1;
    ks.rd_round = 4'(r);
    tick();
    ks.rd_en = 1'b0;
    v = ks.rd_valid;
    k = ks.rd_key;
  endtask

  task automatic check_sched(input string nm);
    logic v;
    logic [127:0] k;
    for (int r = 0; r <= m_nr; r++) begin
      read(r, v, k);
      check($sformatf("%s r%0d valid", nm, r), 128'(v), 128'd1);
      check($sformatf("%s r%0d key", nm, r), k, rk(r));
    end
  endtask

  initial begin
    vec_t tv [3];
    int lat, kl;
    logic v;
    logic [127:0] k;
    logic [255:0] key;
    tv[0] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 41, 10, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tv[1] = '{1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 47, 12, 12, 128'he98ba06f448c773c8ecc720401002202};
    tv[2] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 53, 14, 14, 128'hfe4890d1e6188d0b046df344706c631e};
    ks.start = 1'b0;
    ks.keylen = 2'd0;
    ks.key = '0;
    ks.rd_en = 1'b0;
    ks.rd_round = 4'd0;
`ifdef AES_KS_EQINV_EN
    ks.rd_inv = 1'b0;
`endif
    build_sbox();
    repeat (3) tick();
    check("reset busy", 128'(ks.busy), 128'd0);
    check("reset ready", 128'(ks.ready), 128'd0);
    check("reset nr", 128'(ks.nr), 128'd0);
    check("reset rd_valid", 128'(ks.rd_valid), 128'd0);
    check("reset rd_key", ks.rd_key, 128'd0);
    reset = 1'b0;
    tick();
    ks.keylen = 2'd3;
    ks.start = 1'b1;
    tick();
    ks.start = 1'b0;
    check("rsv keylen busy", 128'(ks.busy), 128'd0);
    tick();
    check("rsv keylen busy later", 128'(ks.busy), 128'd0);
    for (int n = 0; n < 3; n++) begin
      model(tv[n].kl, tv[n].key);
      start_run(tv[n].kl, tv[n].key, -1, lat);
      check($sformatf("kat%0d latency", n), 128'(lat), 128'(tv[n].lat));
      check($sformatf("kat%0d nr", n), 128'(ks.nr), 128'(tv[n].nr));
      read(tv[n].rnd, v, k);
      check($sformatf("kat%0d last round", n), k, tv[n].exp);
      read(0, v, k);
      check($sformatf("kat%0d round0", n), k, tv[n].key[255:128]);
      check_sched($sformatf("kat%0d", n));
    end
    model(tv[0].kl, tv[0].key);
    start_run(tv[0].kl, tv[0].key, -1, lat);
    ks.rd_en = 1'b1;
    for (int r = 10; r >= 0; r--) begin
      ks.rd_round = 4'(r);
      tick();
      check($sformatf("b2b r%0d valid", r), 128'(ks.rd_valid), 128'd1);
      check($sformatf("b2b r%0d key", r), ks.rd_key, rk(r));
    end
    ks.rd_round = 4'd11;
    tick();
    ks.rd_en = 1'b0;
    check("oob valid", 128'(ks.rd_valid), 128'd0);
    check("oob key", ks.rd_key, 128'd0);
    ks.keylen = 2'd3;
    ks.start = 1'b1;
    tick();
    ks.start = 1'b0;
    check("rsv in done busy", 128'(ks.busy), 128'd0);
    check("rsv in done ready", 128'(ks.ready), 128'd1);
    model(tv[2].kl, tv[2].key);
    start_run(tv[2].kl, tv[2].key, 10, lat);
    check("glitch latency", 128'(lat), 128'd53);
    check("glitch nr", 128'(ks.nr), 128'd14);
    check_sched("glitch");
    ks.keylen = 2'd0;
    ks.key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    ks.start = 1'b1;
    tick();
    ks.start = 1'b0;
    repeat (20) tick();
    check("pre-reset busy", 128'(ks.busy), 128'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset ready", 128'(ks.ready), 128'd0);
    check("mid reset busy", 128'(ks.busy), 128'd0);
    read(0, v, k);
    check("not ready valid", 128'(v), 128'd0);
    check("not ready key", k, 128'd0);
    key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    model(0, key);
    start_run(0, key, -1, lat);
    check("after reset latency", 128'(lat), 128'd41);
    check_sched("after reset");
    for (int n = 0; n < 6; n++) begin
      kl = int'($urandom_range(0, 2));
      key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      model(kl, key);
      start_run(kl, key, -1, lat);
      check($sformatf("rnd%0d latency", n), 128'(lat), 128'(1 + 4 * (m_nr + 1) - m_nk));
      check($sformatf("rnd%0d nr", n), 128'(ks.nr), 128'(m_nr));
      check_sched($sformatf("rnd%0d", n));
    end
`ifdef AES_KS_EQINV_EN
    model(tv[0].kl, tv[0].key);
    start_run(tv[0].kl, tv[0].key, -1, lat);
    ks.rd_inv = 1'b1;
    read(0, v, k);
    check("eqinv r0", k, tv[0].key[255:128]);
    read(10, v, k);
    check("eqinv r10", k, tv[0].exp);
    read(1, v, k);
    check("eqinv r1", k, imc(128'ha0fafe1788542cb123a339392a6c7605));
    for (int r = 2; r < 10; r++) begin
      read(r, v, k);
      check($sformatf("eqinv r%0d", r), k, imc(rk(r)));
    end
    ks.rd_inv = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
